apb_req_arbiter: RTL

// Shares the single apb_master between NUM_REQ command sources (JTAG debug port, AHB/AXI-Lite bridges).

---
 rtl/apb_req_arbiter_pkg.sv | 18 +
 rtl/apb_req_arbiter_rr.sv | 34 +++
 rtl/apb_req_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/apb_req_arbiter_pkg.sv
// apb_req_arbiter_pkg: shared widths and FSM state encoding for the APB request arbiter.
//   DEF_* localparams : default parameter values used by the arbiter and its picker
//   state_t           : arbiter FSM states (ARB, ISSUE, WAIT, DONE), 2-bit encoding
package apb_req_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_NUM_REQ     = 2;
    localparam int DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [1:0] {
        S_ARB   = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/apb_req_arbiter_rr.sv
// apb_req_arbiter_rr: combinational round-robin pick among NUM_REQ requesters.
//   req   in  NUM_REQ  request vector
//   ptr   in  IW       index of the last winner; search starts just after it
//   any   out 1        at least one request present
//   grant out NUM_REQ  one-hot grant (0 when no request)
//   idx   out IW       index of the granted requester
module apb_req_arbiter_rr
    import apb_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               any,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx
);

    logic [IW-1:0] c;

    // Scan from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        idx = '0;
        c   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            c = IW'((int'(ptr) + i) % NUM_REQ);
            if (req[c]) idx = c;
        end
        any   = |req;
        grant = any ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: shares one apb_master between NUM_REQ command sources, round-robin.
//   pclock, presetn              clock, asynchronous active-low reset
//   req_valid/write/addr/wdata   packed per-requester commands, held until req_ready
//   req_ready                    one-hot accept pulse
//   rsp_valid/rsp_rdata/rsp_err  one-hot completion pulse with read data and slave error
//   transfer/read/write          command strobes to apb_master
//   apb_paddr/apb_write_data     command address/data to apb_master
//   psel/penable                 observed apb_master phase
//   pready/pslverr/prdata        observed slave response
//   busy                         command in flight
//   timeout_flag                 sticky, ACCESS waited TIMEOUT_CYC cycles
module apb_req_arbiter
    import apb_req_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                          pclock,
    input  logic                          presetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          transfer,
    output logic                          read,
    output logic                          write,
    output logic [ADDR_WIDTH-1:0]         apb_paddr,
    output logic [DATA_WIDTH-1:0]         apb_write_data,
    input  logic                          psel,
    input  logic                          penable,
    input  logic                          pready,
    input  logic                          pslverr,
    input  logic [DATA_WIDTH-1:0]         prdata,
    output logic                          busy,
    output logic                          timeout_flag
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_t                state, state_n;
    logic [IW-1:0]         ptr, gidx, pick;
    logic                  any;
    logic [NUM_REQ-1:0]    grant;
    logic                  cmd_write, sel_write;
    logic [ADDR_WIDTH-1:0] cmd_addr, sel_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata, sel_wdata;
    logic [CW-1:0]         wait_cnt;
    logic                  setup, access_done, active, stalled;

    apb_req_arbiter_rr #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .any   (any),
        .grant (grant),
        .idx   (pick)
    );

    assign setup       = psel && !penable;
    assign access_done = psel && penable && pready;
    assign stalled     = (state == S_WAIT) && !access_done;

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IW'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_ARB:   state_n = any ? S_ISSUE : S_ARB;
            S_ISSUE: state_n = setup ? S_WAIT : S_ISSUE;
            S_WAIT:  state_n = access_done ? S_DONE : S_WAIT;
            default: state_n = S_ARB;
        endcase
    end

    // Command is presented to the master only in ISSUE/WAIT; transfer drops
    // once SETUP is seen so the master never chains into a second transfer.
    assign active         = (state == S_ISSUE) || (state == S_WAIT);
    assign req_ready      = (state == S_ARB) ? grant : '0;
    assign rsp_valid      = (state == S_DONE) ? (NUM_REQ'(1) << gidx) : '0;
    assign transfer       = state == S_ISSUE;
    assign read           = active && !cmd_write;
    assign write          = active && cmd_write;
    assign apb_paddr      = active ? cmd_addr : '0;
    assign apb_write_data = active ? cmd_wdata : '0;
    assign busy           = state != S_ARB;

    always_ff @(posedge pclock or negedge presetn) begin
        if (!presetn) begin
            state        <= S_ARB;
            ptr          <= IW'(NUM_REQ - 1);
            gidx         <= '0;
            cmd_write    <= 1'b0;
            cmd_addr     <= '0;
            cmd_wdata    <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_ARB && any) begin
                ptr       <= pick;
                gidx      <= pick;
                cmd_write <= sel_write;
                cmd_addr  <= sel_addr;
                cmd_wdata <= sel_wdata;
            end
            if (state == S_WAIT && access_done) begin
                rsp_rdata <= cmd_write ? '0 : prdata;
                rsp_err   <= pslverr;
            end
            // Counter is cleared while in ISSUE, so it starts at 0 on WAIT entry
            // and counts only cycles the slave stalls in ACCESS.
            if (state == S_ISSUE) wait_cnt <= '0;
            else if (stalled && wait_cnt != CW'(TIMEOUT_CYC)) wait_cnt <= wait_cnt + 1'b1;
            if (stalled && wait_cnt == CW'(TIMEOUT_CYC - 1)) timeout_flag <= 1'b1;
        end
    end

endmodule
